// File: rtl/math_calculator.sv
// math_calculator: registered signed arithmetic unit.
// Each cycle it samples A and B and registers four results. Sum, Sub and Div
// saturate to the W-bit signed range. Prod is the exact 2W-bit signed product.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; clears every result register
//   A    - signed operand (dividend), W bits
//   B    - signed operand (divisor), W bits
//   Sum  - registered saturated A+B, W bits
//   Sub  - registered saturated A-B, W bits
//   Prod - registered exact A*B, 2W bits
//   Div  - registered saturated A/B, truncated toward zero, W bits
module math_calculator #(
  parameter int unsigned W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  output logic [W-1:0]    Sum,
  output logic [W-1:0]    Sub,
  output logic [2*W-1:0]  Prod,
  output logic [W-1:0]    Div
);

  localparam int unsigned EXT_W  = W + 1;
  localparam int unsigned PROD_W = 2 * W;

  // Two's complement range limits.
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};

  // Clamp a W+1-bit signed value into the W-bit signed range.
  // Overflow shows up as the top two bits disagreeing.
  function automatic logic [W-1:0] sat_w(input logic [EXT_W-1:0] v);
    logic [W-1:0] r;
    if (v[EXT_W-1] != v[EXT_W-2]) begin
      r = v[EXT_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      r = v[W-1:0];
    end
    return r;
  endfunction

  logic [W-1:0]      sum_d, sum_q;
  logic [W-1:0]      sub_d, sub_q;
  logic [PROD_W-1:0] prod_d, prod_q;
  logic [W-1:0]      div_d, div_q;

  logic [EXT_W-1:0]  a_ext;
  logic [EXT_W-1:0]  b_ext;
  logic [EXT_W-1:0]  sum_ext;
  logic [EXT_W-1:0]  sub_ext;

  // Sum and difference computed one bit wider, then clamped.
  always_comb begin
    a_ext   = {A[W-1], A};
    b_ext   = {B[W-1], B};
    sum_ext = a_ext + b_ext;
    sub_ext = a_ext - b_ext;
    sum_d   = sat_w(sum_ext);
    sub_d   = sat_w(sub_ext);
  end

  logic [PROD_W-1:0] a_prod;
  logic [PROD_W-1:0] b_prod;

  // Sign-extending both operands to 2W makes the low 2W bits of the
  // product the exact signed result.
  always_comb begin
    a_prod = {{W{A[W-1]}}, A};
    b_prod = {{W{B[W-1]}}, B};
    prod_d = a_prod * b_prod;
  end

  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;
  logic             q_neg;
  logic [EXT_W-1:0] rem;
  logic [W-1:0]     q_mag;
  logic [EXT_W-1:0] q_ext;
  logic [EXT_W-1:0] q_signed;
  logic             b_zero;

  // Operand magnitudes. MIN negates to 2^(W-1), which still fits in W
  // unsigned bits, so no extra width is needed here.
  always_comb begin
    a_mag  = A[W-1] ? (~A + W'(1)) : A;
    b_mag  = B[W-1] ? (~B + W'(1)) : B;
    q_neg  = A[W-1] ^ B[W-1];
    b_zero = (B == '0);
  end

  // Restoring array divider on the magnitudes, MSB first.
  // The partial remainder stays below b_mag, so W+1 bits hold the shift.
  always_comb begin
    rem   = '0;
    q_mag = '0;
    for (int i = W - 1; i >= 0; i--) begin
      rem = {rem[W-1:0], a_mag[i]};
      if (rem >= {1'b0, b_mag}) begin
        rem      = rem - {1'b0, b_mag};
        q_mag[i] = 1'b1;
      end
    end
  end

  // Sign correction and clamping. The only magnitude overflow is MIN/-1,
  // whose positive quotient 2^(W-1) saturates to MAX. Divide by zero is
  // resolved from the dividend sign.
  always_comb begin
    q_ext    = {1'b0, q_mag};
    q_signed = q_neg ? (~q_ext + EXT_W'(1)) : q_ext;
    if (b_zero) begin
      div_d = A[W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      div_d = sat_w(q_signed);
    end
  end

  // Result registers. Reset takes priority over the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      sub_q  <= '0;
      prod_q <= '0;
      div_q  <= '0;
    end else begin
      sum_q  <= sum_d;
      sub_q  <= sub_d;
      prod_q <= prod_d;
      div_q  <= div_d;
    end
  end

  assign Sum  = sum_q;
  assign Sub  = sub_q;
  assign Prod = prod_q;
  assign Div  = div_q;

endmodule

// File: tb/tb_math_calculator.sv
module tb_math_calculator;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0]   sum;
    logic [W-1:0]   sub;
    logic [2*W-1:0] prod;
    logic [W-1:0]   div;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [W-1:0]   Sum;
  logic [W-1:0]   Sub;
  logic [2*W-1:0] Prod;
  logic [W-1:0]   Div;

  int   tests;
  int   fails;
  exp_t sb_q[$];

  math_calculator #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Sum  (Sum),
    .Sub  (Sub),
    .Prod (Prod),
    .Div  (Div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   q;
    e.sum  = 8'(clamp8(a + b));
    e.sub  = 8'(clamp8(a - b));
    e.prod = 16'(a * b);
    if (b == 0) q = (a >= 0) ? 127 : -128;
    else        q = clamp8(a / b);
    e.div  = 8'(q);
    return e;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    tests++;
    assert (sb_q.size() != 0) else begin
      fails++;
      $error("FAIL %s scoreboard empty: observed size 0, expected >0", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      tests++;
      assert (Sum === e.sum) else begin
        fails++;
        $error("FAIL %s Sum: observed %0d expected %0d", tag, $signed(Sum), $signed(e.sum));
      end
      tests++;
      assert (Sub === e.sub) else begin
        fails++;
        $error("FAIL %s Sub: observed %0d expected %0d", tag, $signed(Sub), $signed(e.sub));
      end
      tests++;
      assert (Prod === e.prod) else begin
        fails++;
        $error("FAIL %s Prod: observed %0d expected %0d", tag, $signed(Prod), $signed(e.prod));
      end
      tests++;
      assert (Div === e.div) else begin
        fails++;
        $error("FAIL %s Div: observed %0d expected %0d", tag, $signed(Div), $signed(e.div));
      end
    end
  endtask

  // Apply one operand pair (or reset), push the expectation, check after the edge.
  task automatic step(input int a, input int b, input bit r, input string tag);
    @(negedge clk);
    A   = 8'(a);
    B   = 8'(b);
    rst = r;
    if (r) sb_q.push_back('0);
    else   sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // Explicit spot checks against hand-derived values.
  task automatic expect_vals(input int s, input int d, input int p, input int q, input string tag);
    tests++;
    assert (Sum === 8'(s) && Sub === 8'(d) && Prod === 16'(p) && Div === 8'(q)) else begin
      fails++;
      $error("FAIL %s: observed %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", tag,
             $signed(Sum), $signed(Sub), $signed(Prod), $signed(Div), s, d, p, q);
    end
  endtask

  int pool[8] = '{0, 1, -1, 127, -128, 2, -2, 126};

  initial begin
    int a;
    int b;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    A   = '0;
    B   = '0;

    step(55, 3, 1'b1, "reset0");
    step(55, 3, 1'b1, "reset1");
    expect_vals(0, 0, 0, 0, "reset_hold");
    step(55, 3, 1'b0, "release");
    expect_vals(58, 52, 165, 18, "release_vals");

    step(10, 5, 1'b0, "basic_10_5");
    expect_vals(15, 5, 50, 2, "basic_10_5_hand");
    step(-3, 7, 1'b0, "basic_m3_7");
    step(15, -4, 1'b0, "basic_15_m4");
    expect_vals(11, 19, -60, -3, "basic_15_m4_hand");
    step(-8, -6, 1'b0, "basic_m8_m6");

    step(100, 100, 1'b0, "sat_pos");
    expect_vals(127, 0, 10000, 1, "sat_pos_hand");
    step(-100, 50, 1'b0, "sat_neg");
    expect_vals(-50, -128, -5000, -2, "sat_neg_hand");

    step(7, 0, 1'b0, "div0_pos");
    step(-5, 0, 1'b0, "div0_neg");
    step(-128, -1, 1'b0, "min_by_m1");
    expect_vals(-128, -127, 128, 127, "min_by_m1_hand");
    step(-7, 2, 1'b0, "trunc_m7_2");
    step(-128, -128, 1'b0, "prod_max");
    expect_vals(-128, 0, 16384, 1, "prod_max_hand");

    for (int i = 0; i < 8; i++) begin
      step(i * 13 - 50, 9 - i * 3, 1'b0, "b2b");
    end
    step(33, 4, 1'b1, "mid_reset");
    step(33, 4, 1'b0, "after_reset");
    step(-77, 5, 1'b0, "after_reset2");

    for (int i = 0; i < 1000; i++) begin
      a = (($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : int'($signed(8'($urandom))));
      b = (($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : int'($signed(8'($urandom))));
      step(a, b, 1'b0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
